dsp_mac_seq: RTL

DSP_MAC_SEQ -- requirements
Module: dsp_mac_seq

---
 rtl/dsp_mac_pkg.sv | 21 ++
 rtl/dsp_mac_seq_if.sv | 34 +++
 rtl/dsp_mac_res_fifo.sv | 72 +++++++
 rtl/dsp_mac_seq.sv | 122 ++++++++++++
 4 files changed

// File: rtl/dsp_mac_pkg.sv
// Shared constants and types for the dsp_mac_seq dot-product engine.
// Optional feature macro: DSP_MAC_CNT_EN (per-result sample count).
package dsp_mac_pkg;

  localparam int DATA_W         = 18;
  localparam int ACC_W          = 48;
  localparam int CNT_W          = 8;
  localparam int RES_LAT        = 5;
  localparam int RES_FIFO_DEPTH = 4;

  // DSP48A1 opmode: X=M, Z=0 starts a new sum; X=M, Z=P accumulates.
  localparam logic [7:0] OPM_MAC_FIRST = 8'h01;
  localparam logic [7:0] OPM_MAC_ACC   = 8'h09;

  typedef logic signed [ACC_W-1:0] res_t;

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/dsp_mac_seq_if.sv
// Sample and result stream bundle for dsp_mac_seq.
// Optional feature macro: DSP_MAC_CNT_EN adds res_cnt.
interface dsp_mac_seq_if;
  import dsp_mac_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_a;
  logic signed [DATA_W-1:0] in_b;
  logic                     in_last;
  logic                     res_valid;
  logic                     res_ready;
  res_t                     res_data;
`ifdef DSP_MAC_CNT_EN
  logic [CNT_W-1:0]         res_cnt;
`endif

  modport slave (
    input  in_valid, in_a, in_b, in_last, res_ready,
`ifdef DSP_MAC_CNT_EN
    output res_cnt,
`endif
    output in_ready, res_valid, res_data
  );

  modport master (
    output in_valid, in_a, in_b, in_last, res_ready,
`ifdef DSP_MAC_CNT_EN
    input  res_cnt,
`endif
    input  in_ready, res_valid, res_data
  );

endinterface

// File: rtl/dsp_mac_res_fifo.sv
// In-order result FIFO. Upstream credit logic guarantees it is never
// written while full. Outputs read as zero while empty or in reset.
// Optional feature macro: DSP_MAC_CNT_EN stores a sample count per entry.
module dsp_mac_res_fifo
  import dsp_mac_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  res_t             wr_data,
`ifdef DSP_MAC_CNT_EN
  input  logic [CNT_W-1:0] wr_cnt,
  output logic [CNT_W-1:0] rd_cnt,
`endif
  input  logic             rd_en,
  output logic             rd_valid,
  output res_t             rd_data
);

  localparam int PTR_W = $clog2(RES_FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(RES_FIFO_DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             do_wr, do_rd;
  res_t             mem_q [RES_FIFO_DEPTH];
`ifdef DSP_MAC_CNT_EN
  logic [CNT_W-1:0] cmem_q [RES_FIFO_DEPTH];
`endif

  assign rd_valid = !rst && (cnt_q != '0);
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
`ifdef DSP_MAC_CNT_EN
  assign rd_cnt   = rd_valid ? cmem_q[rd_ptr_q] : '0;
`endif

  // Pointer and occupancy next-state.
  always_comb begin
    do_wr    = wr_en && (cnt_q != FULL_CNT);
    do_rd    = rd_en && rd_valid;
    wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_wr && !do_rd)      cnt_d = cnt_q + 1'b1;
    else if (!do_wr && do_rd) cnt_d = cnt_q - 1'b1;
  end

  // Control state: pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array, no reset.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q]  <= wr_data;
`ifdef DSP_MAC_CNT_EN
      cmem_q[wr_ptr_q] <= wr_cnt;
`endif
    end
  end

endmodule

// File: rtl/dsp_mac_seq.sv
// Streaming dot-product sequencer around an external DSP48A1 configured
// with A1REG/B1REG/MREG/PREG/OPMODEREG = 1 and the pre-adder bypassed.
// Samples are registered onto dsp_a/dsp_b, the matching opmode trails by
// one cycle to meet OPMODEREG alongside MREG, and a last-tag pipe marks
// when P holds a finished sum so it can be captured into the result FIFO.
// Optional feature macro: DSP_MAC_CNT_EN (per-result sample count).
module dsp_mac_seq
  import dsp_mac_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  dsp_mac_seq_if.slave             bus,
  output logic signed [DATA_W-1:0] dsp_a,
  output logic signed [DATA_W-1:0] dsp_b,
  output logic signed [DATA_W-1:0] dsp_d,
  output logic [ACC_W-1:0]         dsp_c,
  output logic [ACC_W-1:0]         dsp_pcin,
  output logic [7:0]               dsp_opmode,
  output logic                     dsp_carryin,
  output logic                     dsp_ce,
  output logic                     dsp_rst,
  input  logic [ACC_W-1:0]         dsp_p
);

  localparam logic [2:0] CRED_MAX = 3'(RES_FIFO_DEPTH);

  logic                     acc, acc_last, res_pop;
  logic signed [DATA_W-1:0] a_p0_q, a_p0_d, b_p0_q, b_p0_d;
  logic [7:0]               opm_p0_q, opm_p0_d, opm_p1_q, opm_p1_d;
  logic                     first_q, first_d;
  // Stage 0 of the 5-deep tag pipe is the acceptance edge itself; the four
  // registered stages follow. A tag in the last stage means P holds the sum.
  logic [RES_LAT-2:0]       tag_q, tag_d;
  logic [2:0]               credits_q, credits_d;
`ifdef DSP_MAC_CNT_EN
  logic [CNT_W-1:0]         vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0]         cnt_pipe_q [RES_LAT-1];
  logic [CNT_W-1:0]         cnt_pipe_d [RES_LAT-1];
`endif

  assign bus.in_ready = !rst && (credits_q != CRED_MAX);
  assign acc          = bus.in_valid && bus.in_ready;
  assign acc_last     = acc && bus.in_last;
  assign res_pop      = bus.res_valid && bus.res_ready;

  assign dsp_a       = a_p0_q;
  assign dsp_b       = b_p0_q;
  assign dsp_d       = '0;
  assign dsp_c       = '0;
  assign dsp_pcin    = '0;
  assign dsp_carryin = 1'b0;
  assign dsp_opmode  = opm_p1_q;
  assign dsp_ce      = ~rst;
  assign dsp_rst     = rst;

  // Next-state for input stage, opmode delay, tag pipe and credits.
  always_comb begin
    a_p0_d   = acc ? bus.in_a : '0;
    b_p0_d   = acc ? bus.in_b : '0;
    opm_p0_d = (acc && first_q) ? OPM_MAC_FIRST : OPM_MAC_ACC;
    opm_p1_d = opm_p0_q;
    first_d  = acc ? bus.in_last : first_q;
    tag_d    = {tag_q[RES_LAT-3:0], acc_last};
    unique case ({acc_last, res_pop})
      2'b10:   credits_d = credits_q + 1'b1;
      2'b01:   credits_d = credits_q - 1'b1;
      default: credits_d = credits_q;
    endcase
  end

  // p0: sample registered to DSP A/B; p1: opmode lines up with MREG.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_p0_q    <= '0;
      b_p0_q    <= '0;
      opm_p0_q  <= '0;
      opm_p1_q  <= '0;
      first_q   <= 1'b1;
      tag_q     <= '0;
      credits_q <= '0;
    end else begin
      a_p0_q    <= a_p0_d;
      b_p0_q    <= b_p0_d;
      opm_p0_q  <= opm_p0_d;
      opm_p1_q  <= opm_p1_d;
      first_q   <= first_d;
      tag_q     <= tag_d;
      credits_q <= credits_d;
    end
  end

`ifdef DSP_MAC_CNT_EN
  // Running saturating sample count, delayed to line up with its tag.
  always_comb begin
    vec_cnt_d = vec_cnt_q;
    if (acc) vec_cnt_d = first_q ? CNT_W'(1) : cnt_sat_inc(vec_cnt_q);
    cnt_pipe_d[0] = acc_last ? vec_cnt_d : '0;
    for (int i = 1; i < RES_LAT-1; i++) cnt_pipe_d[i] = cnt_pipe_q[i-1];
  end

  // Count datapath registers; first_q overrides any stale count.
  always_ff @(posedge clk) begin
    vec_cnt_q  <= vec_cnt_d;
    cnt_pipe_q <= cnt_pipe_d;
  end
`endif

  dsp_mac_res_fifo u_res_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (tag_q[RES_LAT-2]),
    .wr_data  ($signed(dsp_p)),
`ifdef DSP_MAC_CNT_EN
    .wr_cnt   (cnt_pipe_q[RES_LAT-2]),
    .rd_cnt   (bus.res_cnt),
`endif
    .rd_en    (bus.res_ready),
    .rd_valid (bus.res_valid),
    .rd_data  (bus.res_data)
  );

endmodule
